// File: rtl/rx_lane_sync.sv
// -----------------------------------------------------------------------------
// rx_lane_sync
//
// Lane synchronization controller for the two-lane receive path. Sits between
// the two deserializers and the two 8->32 converters. The datapath is held off
// until both lanes have shown a run of idle (comma) characters and then begin
// payload in the same cycle. Once locked, aligned byte pairs are forwarded with
// idle pairs stripped. Repeated lane errors drop the lock.
//
// Optional feature macro: RX_SYNC_STATS_EN
//   defined   : lock_loss_cnt counts error-driven lock losses (saturates at 255,
//               cleared only by reset)
//   undefined : lock_loss_cnt is tied to 8'h00, no counter is built
//
// Parameters:
//   BC_CODE     idle/comma character
//   LOCK_COUNT  consecutive valid idles required per lane (1..15)
//   ERR_LIMIT   errors while locked that force loss of lock (1..15)
//
// Ports:
//   clk            clock, all logic on rising edge
//   reset          asynchronous active-high reset
//   lane0_data/lane0_valid, lane1_data/lane1_valid  deserializer bytes
//   lane0_out/lane1_out  registered forwarded byte pair
//   lane_en        one-cycle strobe: lane outputs carry a new pair
//   active         lock indicator (state == ACTIVE)
//   state          00 SEARCH, 01 SYNC, 10 ACTIVE
//   err_cnt        error count while ACTIVE
//   lock_loss_cnt  lock-loss event count (see macro above)
// -----------------------------------------------------------------------------
module rx_lane_sync #(
  parameter logic [7:0]  BC_CODE    = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lane0_data,
  input  logic       lane0_valid,
  input  logic [7:0] lane1_data,
  input  logic       lane1_valid,
  output logic [7:0] lane0_out,
  output logic [7:0] lane1_out,
  output logic       lane_en,
  output logic       active,
  output logic [1:0] state,
  output logic [3:0] err_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    SYNC    = 2'b01,
    ACTIVE  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_THR  = LOCK_COUNT[3:0];
  localparam logic [3:0] ERR_THR   = ERR_LIMIT[3:0];

  state_t     state_reg, state_next;
  logic [3:0] cnt0_reg, cnt0_next;
  logic [3:0] cnt1_reg, cnt1_next;
  logic [3:0] err_reg, err_next;
  logic [7:0] out0_reg, out0_next;
  logic [7:0] out1_reg, out1_next;
  logic       en_reg, en_next;
  logic       active_reg;
  logic       lock_loss_evt;

  // Per-lane event classification
  logic idle0, idle1, data0, data1;
  logic both_data, quiet_pair;

  assign idle0 = lane0_valid && (lane0_data == BC_CODE);
  assign idle1 = lane1_valid && (lane1_data == BC_CODE);
  assign data0 = lane0_valid && (lane0_data != BC_CODE);
  assign data1 = lane1_valid && (lane1_data != BC_CODE);
  assign both_data  = data0 && data1;
  // Pairs that neither forward nor count as an error: idle on both, or nothing.
  assign quiet_pair = (idle0 && idle1) || (!lane0_valid && !lane1_valid);

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= SEARCH;
      cnt0_reg   <= 4'd0;
      cnt1_reg   <= 4'd0;
      err_reg    <= 4'd0;
      out0_reg   <= 8'd0;
      out1_reg   <= 8'd0;
      en_reg     <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt0_reg   <= cnt0_next;
      cnt1_reg   <= cnt1_next;
      err_reg    <= err_next;
      out0_reg   <= out0_next;
      out1_reg   <= out1_next;
      en_reg     <= en_next;
      active_reg <= (state_next == ACTIVE);
    end
  end

  // Next-state and datapath logic
  always_comb begin
    logic [3:0] err_sum;
    logic       fwd;
    state_next    = state_reg;
    cnt0_next     = cnt0_reg;
    cnt1_next     = cnt1_reg;
    err_next      = err_reg;
    lock_loss_evt = 1'b0;
    fwd           = 1'b0;
    err_sum       = err_reg + 4'd1;

    case (state_reg)
      SEARCH: begin
        if (idle0)      cnt0_next = sat_inc(cnt0_reg);
        else if (data0) cnt0_next = 4'd0;
        if (idle1)      cnt1_next = sat_inc(cnt1_reg);
        else if (data1) cnt1_next = 4'd0;
        // Lock qualification uses the counts including this edge's update.
        if ((cnt0_next >= LOCK_THR) && (cnt1_next >= LOCK_THR))
          state_next = SYNC;
      end
      SYNC: begin
        if (both_data) begin
          state_next = ACTIVE;
          err_next   = 4'd0;
          fwd        = 1'b1;
        end else if (!quiet_pair) begin
          // Lanes disagree on the start of payload: restart alignment.
          state_next = SEARCH;
          cnt0_next  = 4'd0;
          cnt1_next  = 4'd0;
        end
      end
      ACTIVE: begin
        if (both_data) begin
          fwd = 1'b1;
        end else if (!quiet_pair) begin
          if (err_sum == ERR_THR) begin
            state_next    = SEARCH;
            cnt0_next     = 4'd0;
            cnt1_next     = 4'd0;
            err_next      = 4'd0;
            lock_loss_evt = 1'b1;
          end else begin
            err_next = err_sum;
          end
        end
      end
      default: begin
        state_next = SEARCH;
        cnt0_next  = 4'd0;
        cnt1_next  = 4'd0;
        err_next   = 4'd0;
      end
    endcase

    en_next   = fwd;
    out0_next = fwd ? lane0_data : out0_reg;
    out1_next = fwd ? lane1_data : out1_reg;
  end

`ifdef RX_SYNC_STATS_EN
  logic [7:0] lock_loss_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lock_loss_reg <= 8'd0;
    else if (lock_loss_evt && (lock_loss_reg != 8'hFF))
      lock_loss_reg <= lock_loss_reg + 8'd1;
  end

  assign lock_loss_cnt = lock_loss_reg;
`else
  logic unused_lock_loss;
  assign unused_lock_loss = lock_loss_evt;
  assign lock_loss_cnt    = 8'h00;
`endif

  assign lane0_out = out0_reg;
  assign lane1_out = out1_reg;
  assign lane_en   = en_reg;
  assign active    = active_reg;
  assign state     = state_reg;
  assign err_cnt   = err_reg;

endmodule

// File: tb/tb_rx_lane_sync.sv
module tb_rx_lane_sync;

  localparam logic [7:0] BC = 8'hBC;
  localparam int LOCK = 4;
  localparam int ERRL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lane0_data, lane1_data;
  logic       lane0_valid, lane1_valid;
  logic [7:0] lane0_out, lane1_out;
  logic       lane_en, active;
  logic [1:0] state;
  logic [3:0] err_cnt;
  logic [7:0] lock_loss_cnt;

  int tests  = 0;
  int errors = 0;

  // Reference model (spec-level): 0 SEARCH, 1 SYNC, 2 ACTIVE
  int         m_state, m_c0, m_c1, m_err, m_ll;
  bit         m_en;
  logic [7:0] m_o0, m_o1;

  rx_lane_sync dut (
    .clk(clk), .reset(reset),
    .lane0_data(lane0_data), .lane0_valid(lane0_valid),
    .lane1_data(lane1_data), .lane1_valid(lane1_valid),
    .lane0_out(lane0_out), .lane1_out(lane1_out),
    .lane_en(lane_en), .active(active), .state(state),
    .err_cnt(err_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_c0 = 0; m_c1 = 0; m_err = 0; m_ll = 0;
    m_en = 0; m_o0 = 8'h00; m_o1 = 8'h00;
  endtask

  task automatic model_step(input bit v0, input logic [7:0] d0,
                            input bit v1, input logic [7:0] d1);
    bit i0, i1, x0, x1, quiet;
    i0 = v0 && (d0 == BC);  x0 = v0 && (d0 != BC);
    i1 = v1 && (d1 == BC);  x1 = v1 && (d1 != BC);
    quiet = (i0 && i1) || (!v0 && !v1);
    m_en = 0;
    if (m_state == 0) begin
      if (i0) m_c0 = (m_c0 < 15) ? m_c0 + 1 : 15; else if (x0) m_c0 = 0;
      if (i1) m_c1 = (m_c1 < 15) ? m_c1 + 1 : 15; else if (x1) m_c1 = 0;
      if (m_c0 >= LOCK && m_c1 >= LOCK) m_state = 1;
    end else if (m_state == 1) begin
      if (x0 && x1) begin
        m_state = 2; m_err = 0; m_en = 1; m_o0 = d0; m_o1 = d1;
      end else if (!quiet) begin
        m_state = 0; m_c0 = 0; m_c1 = 0;
      end
    end else begin
      if (x0 && x1) begin
        m_en = 1; m_o0 = d0; m_o1 = d1;
      end else if (!quiet) begin
        m_err = m_err + 1;
        if (m_err == ERRL) begin
          m_state = 0; m_c0 = 0; m_c1 = 0; m_err = 0;
`ifdef RX_SYNC_STATS_EN
          if (m_ll < 255) m_ll = m_ll + 1;
`endif
        end
      end
    end
  endtask

  // Apply one input pair across one rising edge; return #1 after the edge.
  task automatic cycle(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1);
    lane0_valid = v0; lane0_data = d0;
    lane1_valid = v1; lane1_data = d1;
    @(posedge clk);
    #1;
    model_step(v0, d0, v1, d1);
    $display("[TB] t=%0t in %0b:%02h %0b:%02h -> st=%0d en=%0b out=%02h/%02h err=%0d ll=%0d",
             $time, v0, d0, v1, d1, state, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt);
  endtask

  task automatic do_reset();
    lane0_valid = 0; lane1_valid = 0; lane0_data = 0; lane1_data = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic go_sync();
    for (int i = 0; i < LOCK; i++) cycle(1, BC, 1, BC);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d act=%0b en=%0b o=%02h/%02h err=%0d ll=%0d, want all zero",
               state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= LOCK; i++) begin
      cycle(1, BC, 1, BC);
      tests++;
      if (state !== ((i == LOCK) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL lock_idle%0d: state=%0d want %0d", i, state, (i == LOCK) ? 1 : 0);
      end
    end
    cycle(1, 8'h12, 1, 8'h34);
    tests++;
    if ({state, active, lane_en, lane0_out, lane1_out} !== {2'b10, 1'b1, 1'b1, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL lock_first_pair: st=%0d act=%0b en=%0b o=%02h/%02h want 2 1 1 12/34",
               state, active, lane_en, lane0_out, lane1_out);
    end
    cycle(0, 8'h00, 0, 8'h00);
    tests++;
    if ({lane_en, lane0_out, lane1_out} !== {1'b0, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL lock_hold: en=%0b o=%02h/%02h want 0 12/34", lane_en, lane0_out, lane1_out);
    end
  endtask

  task automatic test_interrupted();
    logic [7:0] seq0 [7];
    seq0 = '{BC, BC, 8'h55, BC, BC, BC, BC};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, seq0[i], 1, BC);
      tests++;
      if (state !== ((i == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL interrupted_step%0d: state=%0d want %0d", i, state, (i == 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_skew();
    do_reset();
    go_sync();
    cycle(1, 8'hA0, 1, BC);
    tests++;
    if ({state, lane_en, lock_loss_cnt} !== {2'b00, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL sync_skew: st=%0d en=%0b ll=%0d want 0 0 0", state, lane_en, lock_loss_cnt);
    end
  endtask

  task automatic test_idle_strip();
    logic [7:0] a [3];
    logic [7:0] b [3];
    int pulses;
    a = '{8'h01, BC, 8'h03};
    b = '{8'h02, BC, 8'h04};
    pulses = 0;
    do_reset();
    go_sync();
    cycle(1, 8'h11, 1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      cycle(1, a[i], 1, b[i]);
      if (lane_en) pulses++;
      tests++;
      if (i != 1 && {lane_en, lane0_out, lane1_out} !== {1'b1, a[i], b[i]}) begin
        errors++;
        $display("FAIL strip_pair%0d: en=%0b o=%02h/%02h want 1 %02h/%02h",
                 i, lane_en, lane0_out, lane1_out, a[i], b[i]);
      end else if (i == 1 && {lane_en, lane0_out, lane1_out} !== {1'b0, 8'h01, 8'h02}) begin
        errors++;
        $display("FAIL strip_idle: en=%0b o=%02h/%02h want 0 01/02", lane_en, lane0_out, lane1_out);
      end
    end
    tests++;
    if (pulses != 2 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL strip_summary: pulses=%0d err=%0d want 2 0", pulses, err_cnt);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] ll_exp;
`ifdef RX_SYNC_STATS_EN
    ll_exp = 8'd1;
`else
    ll_exp = 8'd0;
`endif
    do_reset();
    go_sync();
    cycle(1, 8'h11, 1, 8'h22);
    for (int i = 1; i <= 2; i++) begin
      cycle(1, 8'h77, 0, 8'h00);
      tests++;
      if ({state, err_cnt, lane_en} !== {2'b10, i[3:0], 1'b0}) begin
        errors++;
        $display("FAIL loss_err%0d: st=%0d err=%0d en=%0b want 2 %0d 0", i, state, err_cnt, lane_en, i);
      end
    end
    cycle(1, 8'h77, 0, 8'h00);
    tests++;
    if ({state, active, err_cnt, lock_loss_cnt} !== {2'b00, 1'b0, 4'd0, ll_exp}) begin
      errors++;
      $display("FAIL loss_drop: st=%0d act=%0b err=%0d ll=%0d want 0 0 0 %0d",
               state, active, err_cnt, lock_loss_cnt, ll_exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go_sync();
    cycle(1, 8'h5A, 1, 8'hA5);
    cycle(1, 8'h77, 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL async_reset: st=%0d act=%0b en=%0b o=%02h/%02h err=%0d ll=%0d want all zero",
               state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_pair(input int kind, output bit v0, output logic [7:0] d0,
                           output bit v1, output logic [7:0] d1);
    v0 = 1; v1 = 1; d0 = BC; d1 = BC;
    if (kind == 1) begin
      d0 = 8'($urandom_range(0, 255)); if (d0 == BC) d0 = 8'h00;
      d1 = 8'($urandom_range(0, 255)); if (d1 == BC) d1 = 8'h00;
    end else if (kind == 2) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      d0 = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom_range(0, 255));
      d1 = ($urandom_range(0, 3) == 0) ? BC : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic test_random();
    bit v0, v1;
    logic [7:0] d0, d1;
    int kind, len;
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      kind = $urandom_range(0, 2);
      len  = (kind == 0) ? $urandom_range(2, 6) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        rand_pair(kind, v0, d0, v1, d1);
        cycle(v0, d0, v1, d1);
        tests++;
        if ({state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt} !==
            {m_state[1:0], (m_state == 2), m_en, m_o0, m_o1, m_err[3:0], m_ll[7:0]}) begin
          errors++;
          $display("FAIL random_cycle: got st=%0d act=%0b en=%0b o=%02h/%02h err=%0d ll=%0d want st=%0d act=%0b en=%0b o=%02h/%02h err=%0d ll=%0d",
                   state, active, lane_en, lane0_out, lane1_out, err_cnt, lock_loss_cnt,
                   m_state, (m_state == 2), m_en, m_o0, m_o1, m_err, m_ll);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    lane0_valid = 0; lane1_valid = 0; lane0_data = 0; lane1_data = 0;
    model_reset();
    test_reset();
    test_lock();
    test_interrupted();
    test_skew();
    test_idle_strip();
    test_loss_of_lock();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
